// File: rtl/pe_result_collector.sv
// pe_result_collector: per-lane 1-entry holding registers, round-robin arbiter, result FIFO with lane tag.
// Optional feature macro RESULT_COLLECTOR_COUNT_EN adds out_total, a wrapping 32-bit count of output pops.
module pe_result_collector #(
  parameter int NUM_PE = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int LANE_W = $clog2(NUM_PE),
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_PE-1:0]        in_valid,
  output logic [NUM_PE-1:0]        in_ready,
  input  logic [NUM_PE*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [LANE_W-1:0]        out_lane,
`ifdef RESULT_COLLECTOR_COUNT_EN
  output logic [31:0]              out_total,
`endif
  output logic [LVL_W-1:0]         fifo_level
);

  localparam int AW = LVL_W - 1;

  // Handshake: a transfer occurs on a rising edge where valid and ready are both high.
  // Ready never depends on same-cycle valid; the sender holds data stable until the transfer.

  logic [NUM_PE-1:0]        hold_v;
  logic [DATA_W-1:0]        hold_d [NUM_PE];
  logic [LANE_W-1:0]        rr_ptr;
  logic [LANE_W+DATA_W-1:0] fifo_mem [DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [LVL_W-1:0]         level;

  logic [LANE_W-1:0]        grant;
  logic [LANE_W-1:0]        grant_next;
  logic [LANE_W+DATA_W-1:0] head;
  logic                     push;
  logic                     pop;

  // Descending scan so the lane closest to rr_ptr (smallest offset) is assigned last and wins.
  always_comb begin
    int idx;
    idx   = 0;
    grant = rr_ptr;
    for (int k = NUM_PE - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_PE) idx = idx - NUM_PE;
      if (hold_v[idx]) grant = LANE_W'(idx);
    end
  end

  assign grant_next = (grant == LANE_W'(NUM_PE - 1)) ? '0 : grant + LANE_W'(1);

  // Full is judged on the registered level, so a same-cycle pop never frees a slot for a push.
  assign push = (level < LVL_W'(DEPTH)) && (|hold_v);
  assign pop  = out_valid && out_ready;

  assign in_ready   = reset ? '0 : ~hold_v;
  assign out_valid  = (level != '0);
  assign head       = fifo_mem[rd_ptr];
  assign out_data   = out_valid ? head[DATA_W-1:0] : '0;
  assign out_lane   = out_valid ? head[LANE_W+DATA_W-1:DATA_W] : '0;
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_v <= '0;
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      for (int i = 0; i < NUM_PE; i++) begin
        if (in_valid[i] && in_ready[i]) hold_v[i] <= 1'b1;
        else if (push && (grant == LANE_W'(i))) hold_v[i] <= 1'b0;
      end
      if (push) begin
        rr_ptr <= grant_next;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Data storage needs no reset: validity is carried entirely by hold_v and level.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PE; i++) begin
      if (in_valid[i] && in_ready[i]) hold_d[i] <= in_data[i*DATA_W +: DATA_W];
    end
    if (push && !reset) fifo_mem[wr_ptr] <= {grant, hold_d[grant]};
  end

`ifdef RESULT_COLLECTOR_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) out_total <= '0;
    else if (pop) out_total <= out_total + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pe_result_collector.sv
// Testbench for pe_result_collector: directed vectors, expected results queued at stimulus time,
// a negedge monitor pops and compares on every output transfer.
module tb_pe_result_collector;

  localparam int NUM_PE = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int LANE_W = 3;
  localparam int LVL_W  = 5;
  localparam int EW     = LANE_W + DATA_W;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_PE-1:0]        in_valid;
  logic [NUM_PE-1:0]        in_ready;
  logic [NUM_PE*DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [LANE_W-1:0]        out_lane;
  logic [LVL_W-1:0]         fifo_level;
`ifdef RESULT_COLLECTOR_COUNT_EN
  logic [31:0]              out_total;
`endif

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;

  // clock / reset
  always #5 clk = ~clk;

  pe_result_collector #(.NUM_PE(NUM_PE), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_lane   (out_lane),
`ifdef RESULT_COLLECTOR_COUNT_EN
    .out_total  (out_total),
`endif
    .fifo_level (fifo_level)
  );

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [DATA_W-1:0] data_of(input int lane, input int seq);
    return 32'hC000_0000 | (32'(lane) << 16) | 32'(seq);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=%0h:%0h required=none", out_lane, out_data);
        end else begin
          exp_e = exp_q.pop_front();
          check("out_lane", 64'(out_lane), 64'(exp_e[EW-1:DATA_W]));
          check("out_data", 64'(out_data), 64'(exp_e[DATA_W-1:0]));
        end
      end else if (exp_q.size() != 0) begin
        check("stall_head", 64'({out_lane, out_data}), 64'(exp_q[0]));
      end
    end
  end

  // driver tasks (entered at posedge + #1)
  task automatic do_reset(input int n);
    reset    = 1'b1;
    in_valid = '0;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic stream(input logic [NUM_PE-1:0] mask, input int n, input int budget);
    int sent[NUM_PE];
    logic [NUM_PE-1:0] hs;
    int cyc;
    bit done;
    cyc = 0;
    for (int i = 0; i < NUM_PE; i++) sent[i] = 0;
    forever begin
      done = 1'b1;
      for (int i = 0; i < NUM_PE; i++) begin
        if (mask[i] && sent[i] < n) begin
          in_valid[i] = 1'b1;
          in_data[i*DATA_W +: DATA_W] = data_of(i, sent[i]);
          done = 1'b0;
        end else begin
          in_valid[i] = 1'b0;
        end
      end
      if (done) break;
      if (cyc >= budget) begin
        checks++;
        errors++;
        $display("FAIL stream_timeout actual=%0d_cycles required=all_intakes", cyc);
        in_valid = '0;
        break;
      end
      @(negedge clk);
      hs = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_PE; i++) if (hs[i]) sent[i]++;
      cyc++;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d_left required=0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    check({name, "_empty_valid"}, 64'(out_valid), 64'd0);
    check({name, "_empty_level"}, 64'(fifo_level), 64'd0);
  endtask

  initial begin
    int cyc;
    reset     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;

    // reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'h00);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'hFF);
    check("post_rst_out_data", 64'(out_data), 64'd0);
    check("post_rst_out_lane", 64'(out_lane), 64'd0);
`ifdef RESULT_COLLECTOR_COUNT_EN
    check("post_rst_total", 64'(out_total), 64'd0);
`endif

    // single result from lane 3
    @(posedge clk);
    #1;
    exp_q.push_back({3'd3, 32'hDEADBEEF});
    in_valid = 8'h08;
    in_data[3*DATA_W +: DATA_W] = 32'hDEADBEEF;
    @(posedge clk);
    #1 in_valid = '0;
    @(negedge clk);
    check("t2_lat_before_push", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("t2_lat_after_push", 64'(out_valid), 64'd1);
    drain("t2", 20);

    // all lanes at once, rr_ptr back at 0
    @(posedge clk);
    #1 do_reset(2);
    for (int i = 0; i < NUM_PE; i++) begin
      exp_q.push_back({3'(i), 32'h100 + 32'(i)});
      in_data[i*DATA_W +: DATA_W] = 32'h100 + 32'(i);
    end
    in_valid = 8'hFF;
    @(posedge clk);
    #1 in_valid = '0;
    @(negedge clk);
    check("t3_lat_before_push", 64'(out_valid), 64'd0);
    for (int i = 0; i < NUM_PE; i++) begin
      @(negedge clk);
      check("t3_burst_valid", 64'(out_valid), 64'd1);
    end
    drain("t3", 20);

    // lanes 0 and 5 streaming: grants alternate
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({3'd0, data_of(0, k)});
      exp_q.push_back({3'd5, data_of(5, k)});
    end
    stream(8'h21, 4, 40);
    drain("t4", 20);

    // backpressure: 16 in FIFO + 8 held, then release
    @(posedge clk);
    #1 do_reset(1);
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < NUM_PE; i++) exp_q.push_back({3'(i), data_of(i, s)});
    stream(8'hFF, 3, 60);
    @(negedge clk);
    check("t5_full_level", 64'(fifo_level), 64'd16);
    check("t5_full_in_ready", 64'(in_ready), 64'h00);
    check("t5_full_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain("t5", 100);
    check("t5_reopen_in_ready", 64'(in_ready), 64'hFF);

    // reset mid-operation with level 10 and lanes 2..7 held
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < NUM_PE; i++) in_data[i*DATA_W +: DATA_W] = data_of(i, 7);
    in_valid = 8'hFF;
    @(posedge clk);
    #1 in_valid = '0;
    cyc = 0;
    while (fifo_level != 5'd8 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_preload_level", 64'(fifo_level), 64'd8);
    @(posedge clk);
    #1 in_valid = 8'hFF;
    @(posedge clk);
    #1 in_valid = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("t6_pre_level", 64'(fifo_level), 64'd10);
    check("t6_pre_in_ready", 64'(in_ready), 64'h03);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("t6_post_level", 64'(fifo_level), 64'd0);
    check("t6_post_valid", 64'(out_valid), 64'd0);
    check("t6_post_in_ready", 64'(in_ready), 64'hFF);
`ifdef RESULT_COLLECTOR_COUNT_EN
    check("t6_post_total", 64'(out_total), 64'd0);
`endif
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int k = 0; k < 5; k++) exp_q.push_back({3'd2, data_of(2, k)});
    stream(8'h04, 5, 40);
    drain("t6", 20);
`ifdef RESULT_COLLECTOR_COUNT_EN
    check("t6_total_after_5", 64'(out_total), 64'd5);
`endif

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
